// File: rtl/pc_register_pkg.sv
// Shared definitions for the program-counter slice: next-PC select codes,
// controller state encodings and the default reset vector.
package pc_register_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_src_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_register_next_pc_mux.sv
// Combinational next-PC candidate selection plus misalignment detection.
// All arithmetic is 32-bit and wraps modulo 2^32.
module next_pc_mux
  import pc_register_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] cur_pc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] immediate,
  input  logic [25:0] jump_addr,
  output logic [31:0] candidate,
  output logic        misaligned
);

  logic [31:0] branch_target;

  // Word offset scaled to bytes; the shift drops immediate[31:30] by design.
  assign branch_target = pc_plus4 + (immediate << 2);

  always_comb begin
    candidate = pc_plus4;
    case (pc_src)
      PC_SEQ:    candidate = pc_plus4;
      PC_BRANCH: candidate = branch_target;
      PC_JUMP:   candidate = {pc_plus4[31:28], jump_addr, 2'b00};
      PC_HOLD:   candidate = cur_pc;
      default:   candidate = pc_plus4;
    endcase
  end

  assign misaligned = (candidate[1:0] != 2'b00);

endmodule

// File: rtl/pc_register.sv
// Program-counter register with RUN/HALTED control, sticky misaligned-target
// error flag and a one-cycle commit pulse.
module pc_register
  import pc_register_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic        halt,
  input  logic [31:0] pcPlus4,
  input  logic [31:0] immediate,
  input  logic [25:0] jumpAddr,
  output logic [31:0] curPC,
  output logic        halted,
  output logic        addrErr,
  output logic        pcUpdated
);

  pc_state_t   state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        err_reg, err_next;
  logic        upd_reg, upd_next;
  logic [31:0] candidate;
  logic        misaligned;

  next_pc_mux u_next_pc_mux (
    .pc_src     (PCSrc),
    .cur_pc     (pc_reg),
    .pc_plus4   (pcPlus4),
    .immediate  (immediate),
    .jump_addr  (jumpAddr),
    .candidate  (candidate),
    .misaligned (misaligned)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    err_next   = err_reg;
    upd_next   = 1'b0;
    case (state_reg)
      ST_RUN: begin
        // halt only counts on a write-enabled cycle, and outranks misalignment
        if (PCWre) begin
          if (halt) begin
            state_next = ST_HALTED;
          end else if (misaligned) begin
            state_next = ST_HALTED;
            err_next   = 1'b1;
          end else begin
            pc_next  = candidate;
            upd_next = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= ST_RUN;
      pc_reg    <= RESET_PC;
      err_reg   <= 1'b0;
      upd_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      err_reg   <= err_next;
      upd_reg   <= upd_next;
    end
  end

  assign curPC     = pc_reg;
  assign halted    = (state_reg == ST_HALTED);
  assign addrErr   = err_reg;
  assign pcUpdated = upd_reg;

endmodule

// File: tb/tb_pc_register.sv
// Scoreboard bench for pc_register: directed vectors push hand-computed
// expected outputs; a monitor pops and compares one entry per clock.
module tb_pc_register;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic        halt;
  logic [31:0] pcPlus4;
  logic [31:0] immediate;
  logic [25:0] jumpAddr;
  logic [31:0] curPC;
  logic        halted;
  logic        addrErr;
  logic        pcUpdated;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        hlt;
    logic        err;
    logic        upd;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  pc_register dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .halt      (halt),
    .pcPlus4   (pcPlus4),
    .immediate (immediate),
    .jumpAddr  (jumpAddr),
    .curPC     (curPC),
    .halted    (halted),
    .addrErr   (addrErr),
    .pcUpdated (pcUpdated)
  );

  always #5 CLK = ~CLK;

  // Apply one input vector across one rising edge and queue its expected result.
  task automatic step(input string name, input logic rst, input logic we,
                      input logic [1:0] src, input logic hl,
                      input logic [31:0] p4, input logic [31:0] imm,
                      input logic [25:0] ja, input logic [31:0] e_pc,
                      input logic e_hlt, input logic e_err, input logic e_upd);
    exp_t e;
    Reset     = rst;
    PCWre     = we;
    PCSrc     = src;
    halt      = hl;
    pcPlus4   = p4;
    immediate = imm;
    jumpAddr  = ja;
    @(posedge CLK);
    #1;
    e.name = name;
    e.pc   = e_pc;
    e.hlt  = e_hlt;
    e.err  = e_err;
    e.upd  = e_upd;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (curPC !== e.pc || halted !== e.hlt || addrErr !== e.err || pcUpdated !== e.upd) begin
          tests_failed++;
          $display("FAIL %s: got pc=%h halted=%b addrErr=%b pcUpdated=%b, expected pc=%h halted=%b addrErr=%b pcUpdated=%b",
                   e.name, curPC, halted, addrErr, pcUpdated, e.pc, e.hlt, e.err, e.upd);
        end else begin
          $display("ok   %s: pc=%h halted=%b addrErr=%b pcUpdated=%b",
                   e.name, curPC, halted, addrErr, pcUpdated);
        end
      end
    end
  end

  initial begin : driver
    Reset = 1'b1; PCWre = 1'b0; PCSrc = 2'b00; halt = 1'b0;
    pcPlus4 = '0; immediate = '0; jumpAddr = '0;
    @(posedge CLK);
    #1;
    //    name            rst we  src   hlt pcPlus4       immediate     jump      exp pc        h     e     u
    step("reset",         1, 0, 2'b00, 0, 32'h0,        32'h0,        26'h0,  32'h0000_0000, 0, 0, 0);
    step("seq_4",         0, 1, 2'b00, 0, 32'h4,        32'h0,        26'h0,  32'h0000_0004, 0, 0, 1);
    step("seq_8",         0, 1, 2'b00, 0, 32'h8,        32'h0,        26'h0,  32'h0000_0008, 0, 0, 1);
    step("seq_c",         0, 1, 2'b00, 0, 32'hC,        32'h0,        26'h0,  32'h0000_000C, 0, 0, 1);
    step("seq_10",        0, 1, 2'b00, 0, 32'h10,       32'h0,        26'h0,  32'h0000_0010, 0, 0, 1);
    step("branch_back",   0, 1, 2'b01, 0, 32'h14,       32'hFFFF_FFFE, 26'h0, 32'h0000_000C, 0, 0, 1);
    step("jump",          0, 1, 2'b10, 0, 32'h4000_0008, 32'h0,       26'h40, 32'h4000_0100, 0, 0, 1);
    step("hold_commit",   0, 1, 2'b11, 0, 32'h4000_0104, 32'h0,       26'h0,  32'h4000_0100, 0, 0, 1);
    step("branch_wrap",   0, 1, 2'b01, 0, 32'hFFFF_FFFC, 32'h1,       26'h0,  32'h0000_0000, 0, 0, 1);
    step("stall_halt_1",  0, 0, 2'b00, 1, 32'h4,        32'h0,        26'h0,  32'h0000_0000, 0, 0, 0);
    step("stall_halt_2",  0, 0, 2'b00, 1, 32'h4,        32'h0,        26'h0,  32'h0000_0000, 0, 0, 0);
    step("halt",          0, 1, 2'b00, 1, 32'h4,        32'h0,        26'h0,  32'h0000_0000, 1, 0, 0);
    step("halted_frozen", 0, 1, 2'b00, 0, 32'h4,        32'h0,        26'h0,  32'h0000_0000, 1, 0, 0);
    step("halted_no_err", 0, 1, 2'b00, 0, 32'h6,        32'h0,        26'h0,  32'h0000_0000, 1, 0, 0);
    step("reset_mid_halt",1, 1, 2'b00, 1, 32'h8,        32'h0,        26'h0,  32'h0000_0000, 0, 0, 0);
    step("seq_4b",        0, 1, 2'b00, 0, 32'h4,        32'h0,        26'h0,  32'h0000_0004, 0, 0, 1);
    step("misaligned",    0, 1, 2'b00, 0, 32'h6,        32'h0,        26'h0,  32'h0000_0004, 1, 1, 0);
    step("err_sticky",    0, 1, 2'b00, 0, 32'h8,        32'h0,        26'h0,  32'h0000_0004, 1, 1, 0);
    step("reset_clr_err", 1, 0, 2'b00, 0, 32'h0,        32'h0,        26'h0,  32'h0000_0000, 0, 0, 0);
    step("halt_beats_mis",0, 1, 2'b00, 1, 32'h6,        32'h0,        26'h0,  32'h0000_0000, 1, 0, 0);
    step("reset_2",       1, 0, 2'b00, 0, 32'h0,        32'h0,        26'h0,  32'h0000_0000, 0, 0, 0);
    step("seq_8b",        0, 1, 2'b00, 0, 32'h8,        32'h0,        26'h0,  32'h0000_0008, 0, 0, 1);
    step("reset_wins",    1, 1, 2'b00, 0, 32'hC,        32'h0,        26'h0,  32'h0000_0000, 0, 0, 0);
    Reset = 1'b0; PCWre = 1'b0; halt = 1'b0;
    repeat (20) begin
      if (exp_q.size() != 0) @(negedge CLK);
    end
    @(posedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
